fir_error_monitor: RTL and testbench



---
 rtl/fir_mon_pkg.sv | 28 ++
 rtl/fir_error_monitor_abs_diff_stage.sv | 48 ++++
 rtl/fir_error_monitor.sv | 167 ++++++++++++++++
 tb/tb_fir_error_monitor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_mon_pkg.sv
// Shared types and width helpers for the FIR error monitor.
//   state_t          : monitor FSM states
//   DEF_*            : default sample width / window configuration
//   sum_w(), sq_w()  : accumulator widths sized so a full window cannot overflow
package fir_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_WINDOW   = 256;
    localparam int unsigned DEF_WIN_LOG2 = 8;

    // Sum of WINDOW values each below 2**data_w
    function automatic int unsigned sum_w(input int unsigned data_w, input int unsigned win_log2);
        return data_w + win_log2;
    endfunction

    // Sum of WINDOW squares each below 2**(2*data_w)
    function automatic int unsigned sq_w(input int unsigned data_w, input int unsigned win_log2);
        return 2 * data_w + win_log2;
    endfunction

endpackage

// File: rtl/fir_error_monitor_abs_diff_stage.sv
// abs_diff_stage: first pipeline stage of the error monitor.
// Registers |approx - exact| on every accepted sample plus a valid flag that
// tells the accumulator stage to consume it on the following edge.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   accept         : sample accepted this cycle
//   approx_sample  : approximate FIR output
//   exact_sample   : exact FIR output
//   abs_q          : registered absolute error
//   vld_q          : abs_q holds a fresh accepted sample
module abs_diff_stage
    import fir_mon_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic [DATA_W-1:0] approx_sample,
    input  logic [DATA_W-1:0] exact_sample,
    output logic [DATA_W-1:0] abs_q,
    output logic              vld_q
);

    logic [DATA_W:0]   diff_c;
    logic [DATA_W:0]   mag_c;
    logic [DATA_W-1:0] abs_c;

    // One extra bit keeps the sign; the magnitude of any difference fits DATA_W
    always_comb begin
        diff_c = {1'b0, approx_sample} - {1'b0, exact_sample};
        mag_c  = diff_c[DATA_W] ? (~diff_c + (DATA_W + 1)'(1)) : diff_c;
        abs_c  = DATA_W'(mag_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            abs_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= accept;
            if (accept) begin
                abs_q <= abs_c;
            end
        end
    end

endmodule

// File: rtl/fir_error_monitor.sv
// fir_error_monitor: measures the error of an approximate-adder FIR against the
// exact FIR over a window of WINDOW accepted samples and reports once per window.
// Build option: define SQ_ERR_EN to add the sum_sq_err output and its multiplier.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : begin a new window (honoured in IDLE or DONE only)
//   sample_valid   : approx/exact samples valid this cycle
//   approx_sample  : approximate FIR output
//   exact_sample   : exact FIR output, time-aligned
//   busy           : window in progress (ACCUM or DRAIN)
//   done           : one-cycle pulse when the results are final
//   err_count      : samples with nonzero error
//   max_abs_err    : largest absolute error
//   sum_abs_err    : sum of absolute errors
//   mean_abs_err   : sum_abs_err / WINDOW (combinational from the sum register)
//   sum_sq_err     : sum of squared errors (SQ_ERR_EN only)
module fir_error_monitor
    import fir_mon_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned WINDOW   = DEF_WINDOW,
    parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2,
    parameter int unsigned SUM_W    = sum_w(DATA_W, WIN_LOG2)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sample_valid,
    input  logic [DATA_W-1:0]     approx_sample,
    input  logic [DATA_W-1:0]     exact_sample,
    output logic                  busy,
    output logic                  done,
    output logic [WIN_LOG2:0]     err_count,
    output logic [DATA_W-1:0]     max_abs_err,
    output logic [SUM_W-1:0]      sum_abs_err,
    output logic [DATA_W-1:0]     mean_abs_err
`ifdef SQ_ERR_EN
    ,
    output logic [sq_w(DATA_W, WIN_LOG2)-1:0] sum_sq_err
`endif
);

    localparam int unsigned CNT_W = WIN_LOG2 + 1;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  sample_cnt;
    logic              accept_c;
    logic              last_c;
    logic              clear_c;
    logic              busy_nxt;
    logic              done_nxt;
    logic [DATA_W-1:0] abs_q;
    logic              vld_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (accept_c && last_c) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded controls; busy/done are computed one edge early and registered
    always_comb begin
        accept_c = 1'b0;
        last_c   = 1'b0;
        clear_c  = 1'b0;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        accept_c = (state == ACCUM) && sample_valid;
        last_c   = (sample_cnt == CNT_W'(WINDOW - 1));
        clear_c  = ((state == IDLE) || (state == DONE)) && start;
        busy_nxt = (state_nxt == ACCUM) || (state_nxt == DRAIN);
        // The last sample reaches the accumulators on the DRAIN edge
        done_nxt = (state == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

    // Accepted-sample counter
    always_ff @(posedge clk) begin
        if (rst || clear_c) begin
            sample_cnt <= '0;
        end else if (accept_c) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
        end
    end

    abs_diff_stage #(
        .DATA_W (DATA_W)
    ) u_abs_diff (
        .clk           (clk),
        .rst           (rst),
        .accept        (accept_c),
        .approx_sample (approx_sample),
        .exact_sample  (exact_sample),
        .abs_q         (abs_q),
        .vld_q         (vld_q)
    );

    // Stage 2 accumulators
    always_ff @(posedge clk) begin
        if (rst || clear_c) begin
            err_count   <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
        end else if (vld_q) begin
            sum_abs_err <= sum_abs_err + SUM_W'(abs_q);
            if (abs_q > max_abs_err) begin
                max_abs_err <= abs_q;
            end
            if (abs_q != '0) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

    assign mean_abs_err = DATA_W'(sum_abs_err >> WIN_LOG2);

`ifdef SQ_ERR_EN
    localparam int unsigned SQ_W = sq_w(DATA_W, WIN_LOG2);

    logic [2*DATA_W-1:0] sq_c;

    always_comb begin
        sq_c = (2 * DATA_W)'(abs_q) * (2 * DATA_W)'(abs_q);
    end

    always_ff @(posedge clk) begin
        if (rst || clear_c) begin
            sum_sq_err <= '0;
        end else if (vld_q) begin
            sum_sq_err <= sum_sq_err + SQ_W'(sq_c);
        end
    end
`endif

endmodule

// File: tb/tb_fir_error_monitor.sv
// Testbench for fir_error_monitor: table of window scenarios (constant
// expectations or a reference model over the accepted samples), plus a
// mid-window reset sequence.
module tb_fir_error_monitor;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned WINDOW   = 256;
    localparam int unsigned WIN_LOG2 = 8;
    localparam int unsigned SUM_W    = DATA_W + WIN_LOG2;
    localparam int unsigned SQ_W     = 2 * DATA_W + WIN_LOG2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              sample_valid;
    logic [DATA_W-1:0] approx_sample;
    logic [DATA_W-1:0] exact_sample;
    logic              busy;
    logic              done;
    logic [WIN_LOG2:0] err_count;
    logic [DATA_W-1:0] max_abs_err;
    logic [SUM_W-1:0]  sum_abs_err;
    logic [DATA_W-1:0] mean_abs_err;
`ifdef SQ_ERR_EN
    logic [SQ_W-1:0]   sum_sq_err;
`endif

    fir_error_monitor dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .sample_valid  (sample_valid),
        .approx_sample (approx_sample),
        .exact_sample  (exact_sample),
        .busy          (busy),
        .done          (done),
        .err_count     (err_count),
        .max_abs_err   (max_abs_err),
        .sum_abs_err   (sum_abs_err),
        .mean_abs_err  (mean_abs_err)
`ifdef SQ_ERR_EN
        ,
        .sum_sq_err    (sum_sq_err)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int              pat;    // data pattern
        int              gap;    // 0 valid always, 1 every other cycle, 2 random
        bit              mid;    // pulse start during ACCUM
        int              extra;  // valids driven after the window closes
        bit              model;  // expectations from reference model
        longint unsigned err;
        longint unsigned mx;
        longint unsigned sum;
        longint unsigned mean;
        longint unsigned sq;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gen(input int pat, input int idx, output logic [DATA_W-1:0] a,
                       output logic [DATA_W-1:0] e);
        int x;
        int y;
        x = int'($urandom_range(0, 65535));
        case (pat)
            0: begin a = 16'(x); e = 16'(x); end
            1: begin a = 16'd99; e = 16'd100; end
            2: begin
                if (idx == 37) begin a = 16'h0000; e = 16'hFFFF; end
                else begin a = 16'(x); e = 16'(x); end
            end
            3: begin a = 16'($urandom); e = 16'($urandom); end
            4: begin
                x = int'($urandom_range(3, 65532));
                e = 16'(x);
                a = ($urandom_range(0, 1) == 1) ? 16'(x + 3) : 16'(x - 3);
            end
            default: begin
                y = x + int'($urandom_range(0, 8)) - 4;
                if (y < 0) y = 0;
                if (y > 65535) y = 65535;
                a = 16'(y);
                e = 16'(x);
            end
        endcase
    endtask

    task automatic chk_results(input string tag, input longint unsigned e_err,
                               input longint unsigned e_max, input longint unsigned e_sum,
                               input longint unsigned e_mean, input longint unsigned e_sq);
        chk({tag, "_err_count"}, 64'(err_count), e_err);
        chk({tag, "_max"}, 64'(max_abs_err), e_max);
        chk({tag, "_sum"}, 64'(sum_abs_err), e_sum);
        chk({tag, "_mean"}, 64'(mean_abs_err), e_mean);
`ifdef SQ_ERR_EN
        chk({tag, "_sq"}, 64'(sum_sq_err), e_sq);
`else
        if (e_sq > 64'd0 && e_sq == 64'd0) $display("unreachable");
`endif
    endtask

    task automatic run_window(input int row, input vec_t v);
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] e;
        int acc;
        int cyc;
        int kmax;
        bit vld;
        int q[$];
        longint unsigned x_err, x_max, x_sum, x_sq;
        string tag;
        tag = $sformatf("row%0d", row);
        acc = 0;
        cyc = 0;
        // start together with a large-error sample that must not be accepted
        start = 1'b1;
        sample_valid = 1'b1;
        approx_sample = 16'hFFFF;
        exact_sample = 16'h0000;
        step();
        start = 1'b0;
        chk({tag, "_start_busy"}, 64'(busy), 64'd1);
        chk({tag, "_start_done"}, 64'(done), 64'd0);
        chk_results({tag, "_start"}, 0, 0, 0, 0, 0);
        while (acc < int'(WINDOW) && cyc < 4000) begin
            case (v.gap)
                0: vld = 1'b1;
                1: vld = (cyc % 2) == 1;
                default: vld = ($urandom_range(0, 3) != 0);
            endcase
            gen(v.pat, acc, a, e);
            sample_valid = vld;
            approx_sample = a;
            exact_sample = e;
            start = v.mid && (acc == 100);
            if (vld) begin
                q.push_back((a >= e) ? int'(a) - int'(e) : int'(e) - int'(a));
                acc++;
            end
            step();
            cyc++;
        end
        start = 1'b0;
        if (acc < int'(WINDOW)) begin
            chk({tag, "_accept_timeout"}, 64'(acc), 64'(WINDOW));
            return;
        end
        // Just after the WINDOW-th acceptance edge: draining
        chk({tag, "_drain_done"}, 64'(done), 64'd0);
        chk({tag, "_drain_busy"}, 64'(busy), 64'd1);
        if (v.model) begin
            x_err = 0; x_max = 0; x_sum = 0; x_sq = 0;
            foreach (q[i]) begin
                if (q[i] != 0) x_err++;
                if (longint'(q[i]) > x_max) x_max = longint'(q[i]);
                x_sum += longint'(q[i]);
                x_sq  += longint'(q[i]) * longint'(q[i]);
            end
        end else begin
            x_err = v.err; x_max = v.mx; x_sum = v.sum; x_sq = v.sq;
        end
        kmax = (v.extra > 2) ? v.extra + 1 : 3;
        for (int k = 1; k <= kmax; k++) begin
            gen(3, 0, a, e);
            sample_valid = (k <= v.extra);
            approx_sample = a;
            exact_sample = e;
            step();
            chk($sformatf("%s_done_k%0d", tag, k), 64'(done), (k == 1) ? 64'd1 : 64'd0);
            chk($sformatf("%s_busy_k%0d", tag, k), 64'(busy), 64'd0);
            if (k == 1) chk_results({tag, "_at_done"}, x_err, x_max, x_sum,
                                    v.model ? (x_sum >> WIN_LOG2) : v.mean, x_sq);
        end
        sample_valid = 1'b0;
        chk_results({tag, "_held"}, x_err, x_max, x_sum,
                    v.model ? (x_sum >> WIN_LOG2) : v.mean, x_sq);
    endtask

    initial begin
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] e;

        tbl[0] = '{0, 0, 1'b0, 0,  1'b0, 0,   0,     0,     0,   0};
        tbl[1] = '{1, 0, 1'b0, 0,  1'b0, 256, 1,     256,   1,   256};
        tbl[2] = '{2, 0, 1'b0, 0,  1'b0, 1,   65535, 65535, 255, 64'd4294836225};
        tbl[3] = '{1, 1, 1'b1, 10, 1'b0, 256, 1,     256,   1,   256};
        tbl[4] = '{4, 0, 1'b0, 0,  1'b0, 256, 3,     768,   3,   2304};
        tbl[5] = '{3, 2, 1'b0, 0,  1'b1, 0,   0,     0,     0,   0};
        tbl[6] = '{5, 2, 1'b1, 5,  1'b1, 0,   0,     0,     0,   0};
        tbl[7] = '{3, 1, 1'b0, 3,  1'b1, 0,   0,     0,     0,   0};

        rst = 1'b1;
        start = 1'b0;
        sample_valid = 1'b0;
        approx_sample = '0;
        exact_sample = '0;
        step();
        step();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk_results("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();

        for (int r = 0; r < 8; r++) begin
            run_window(r, tbl[r]);
        end

        // Reset after 100 accepted samples discards the window
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            gen(3, i, a, e);
            sample_valid = 1'b1;
            approx_sample = a;
            exact_sample = e;
            step();
        end
        sample_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk_results("midrst", 0, 0, 0, 0, 0);
        // Valids without start stay ignored and no done appears
        for (int i = 0; i < 8; i++) begin
            gen(3, i, a, e);
            sample_valid = 1'b1;
            approx_sample = a;
            exact_sample = e;
            step();
            chk($sformatf("postrst_done_%0d", i), 64'(done), 64'd0);
            chk($sformatf("postrst_busy_%0d", i), 64'(busy), 64'd0);
        end
        sample_valid = 1'b0;
        chk_results("postrst", 0, 0, 0, 0, 0);
        run_window(8, tbl[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
